// File: rtl/dp_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : dp_ctrl_pkg
// Brief   : Encodings, state type and step decoder for the dp_seq_ctrl block.
// Revision: 1.0 - initial release
// ============================================================================
package dp_ctrl_pkg;

  localparam logic [2:0] c_cmd_nop   = 3'b000;
  localparam logic [2:0] c_cmd_lda   = 3'b001;
  localparam logic [2:0] c_cmd_ldb   = 3'b010;
  localparam logic [2:0] c_cmd_add   = 3'b011;
  localparam logic [2:0] c_cmd_sub   = 3'b100;
  localparam logic [2:0] c_cmd_movab = 3'b101;
  localparam logic [2:0] c_cmd_swap  = 3'b110;
  localparam logic [2:0] c_cmd_clr   = 3'b111;

  localparam logic [1:0] c_sel_ext  = 2'b00;
  localparam logic [1:0] c_sel_alu  = 2'b01;
  localparam logic [1:0] c_sel_zero = 2'b10;

  localparam logic [1:0] c_alu_add   = 2'b00;
  localparam logic [1:0] c_alu_sub   = 2'b01;
  localparam logic [1:0] c_alu_xor   = 2'b10;
  localparam logic [1:0] c_alu_passa = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_S1   = 2'd1,
    ST_S2   = 2'd2,
    ST_S3   = 2'd3
  } state_t;

  typedef struct packed {
    logic       load_a;
    logic       load_b;
    logic [1:0] in_sel;
    logic [1:0] alu_op;
    logic       done;
  } step_t;

  // Datapath controls for one step; anything outside a defined step is all-zero.
  function automatic step_t decode_step(input state_t st, input logic [2:0] c);
    step_t s;
    s = '0;
    case (st)
      ST_S1: begin
        s.done = (c != c_cmd_swap);
        case (c)
          c_cmd_lda:   begin s.load_a = 1'b1; s.in_sel = c_sel_ext; end
          c_cmd_ldb:   begin s.load_b = 1'b1; s.in_sel = c_sel_ext; end
          c_cmd_add:   begin s.load_a = 1'b1; s.in_sel = c_sel_alu; s.alu_op = c_alu_add; end
          c_cmd_sub:   begin s.load_a = 1'b1; s.in_sel = c_sel_alu; s.alu_op = c_alu_sub; end
          c_cmd_movab: begin s.load_b = 1'b1; s.in_sel = c_sel_alu; s.alu_op = c_alu_passa; end
          c_cmd_swap:  begin s.load_a = 1'b1; s.in_sel = c_sel_alu; s.alu_op = c_alu_xor; end
          c_cmd_clr:   begin s.load_a = 1'b1; s.load_b = 1'b1; s.in_sel = c_sel_zero; end
          default:     ;
        endcase
      end
      ST_S2: begin
        s.load_b = 1'b1;
        s.in_sel = c_sel_alu;
        s.alu_op = c_alu_xor;
      end
      ST_S3: begin
        s.load_a = 1'b1;
        s.in_sel = c_sel_alu;
        s.alu_op = c_alu_xor;
        s.done   = 1'b1;
      end
      default: ;
    endcase
    return s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dp_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : dp_seq_ctrl
// Brief   : Command sequencer for the two-register 4-bit datapath (A/B, mux, ALU).
// Revision: 1.0 - initial release
// ============================================================================
module dp_seq_ctrl
  import dp_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  input  logic [2:0] cmd,
  input  logic [3:0] data_in,
  output logic       cmd_ready,
  output logic       load_a,
  output logic       load_b,
  output logic [1:0] in_sel,
  output logic [1:0] alu_op,
  output logic [3:0] ext_data,
  output logic       busy,
  output logic       done
);

  state_t     r_state;
  logic [2:0] r_cmd;
  logic [3:0] r_ext;
  step_t      r_step;
  logic       r_ready;

  state_t     w_nxt_state;
  logic [2:0] w_nxt_cmd;
  logic       w_accept;

  assign w_accept = cmd_valid && r_ready;

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_cmd   = r_cmd;
    case (r_state)
      ST_IDLE: if (w_accept) begin
        w_nxt_state = ST_S1;
        w_nxt_cmd   = cmd;
      end
      ST_S1:   w_nxt_state = (r_cmd == c_cmd_swap) ? ST_S2 : ST_IDLE;
      ST_S2:   w_nxt_state = ST_S3;
      ST_S3:   w_nxt_state = ST_IDLE;
      default: w_nxt_state = ST_IDLE;
    endcase
  end

  // Step outputs are decoded from the next state so they are registered yet
  // still line up with the cycle of the state they belong to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cmd   <= c_cmd_nop;
      r_ext   <= 4'h0;
      r_step  <= '0;
      r_ready <= 1'b1;
    end else begin
      r_state <= w_nxt_state;
      r_cmd   <= w_nxt_cmd;
      r_step  <= decode_step(w_nxt_state, w_nxt_cmd);
      r_ready <= (w_nxt_state == ST_IDLE);
      if (w_accept) begin
        r_ext <= data_in;
      end
    end
  end

  assign cmd_ready = r_ready;
  assign busy      = !r_ready;
  assign load_a    = r_step.load_a;
  assign load_b    = r_step.load_b;
  assign in_sel    = r_step.in_sel;
  assign alu_op    = r_step.alu_op;
  assign done      = r_step.done;
  assign ext_data  = r_ext;

endmodule
`default_nettype wire

// File: tb/tb_dp_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_dp_seq_ctrl
// Brief   : Controller wrapped with a behavioural A/B datapath, checked against
//           command-level expectations.
// Revision: 1.0 - initial release
// ============================================================================
module tb_dp_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [2:0] cmd = 3'd0;
  logic [3:0] data_in = 4'd0;
  logic       cmd_ready, load_a, load_b, busy, done;
  logic [1:0] in_sel, alu_op;
  logic [3:0] ext_data;

  logic [3:0] ra = 4'h0;
  logic [3:0] rb = 4'h0;
  logic [3:0] w_alu, w_mux;
  logic [3:0] ma = 4'h0;
  logic [3:0] mb = 4'h0;

  int n_cmp  = 0;
  int n_fail = 0;

  dp_seq_ctrl dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd(cmd), .data_in(data_in),
    .cmd_ready(cmd_ready), .load_a(load_a), .load_b(load_b), .in_sel(in_sel),
    .alu_op(alu_op), .ext_data(ext_data), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Lab datapath: registers keep their contents across controller reset.
  always_comb begin
    w_alu = 4'h0;
    case (alu_op)
      2'b00: w_alu = ra + rb;
      2'b01: w_alu = ra - rb;
      2'b10: w_alu = ra ^ rb;
      default: w_alu = ra;
    endcase
    w_mux = 4'h0;
    case (in_sel)
      2'b00: w_mux = ext_data;
      2'b01: w_mux = w_alu;
      default: w_mux = 4'h0;
    endcase
  end

  always @(posedge clk) begin
    if (load_a) ra <= w_mux;
    if (load_b) rb <= w_mux;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_idle(input string name);
    chk({name, "_ready"}, cmd_ready, 1);
    chk({name, "_busy"}, busy, 0);
    chk({name, "_loads"}, {load_a, load_b}, 0);
    chk({name, "_sel_op"}, {in_sel, alu_op}, 0);
    chk({name, "_done"}, done, 0);
  endtask

  // Issue one command and check latency, strobe counts, ext_data and registers
  // against a command-level model of A and B.
  task automatic run_cmd(input logic [2:0] c, input logic [3:0] d);
    logic [3:0] ea, eb;
    int ecyc, ena, enb, cyc, na, nb, waited;
    ea = ma; eb = mb; ecyc = 1; ena = 0; enb = 0;
    case (c)
      3'd1: begin ea = d;            ena = 1; end
      3'd2: begin eb = d;            enb = 1; end
      3'd3: begin ea = 4'(ma + mb);  ena = 1; end
      3'd4: begin ea = 4'(ma - mb);  ena = 1; end
      3'd5: begin eb = ma;           enb = 1; end
      3'd6: begin ea = mb; eb = ma;  ena = 2; enb = 1; ecyc = 3; end
      3'd7: begin ea = 0; eb = 0;    ena = 1; enb = 1; end
      default: ;
    endcase
    @(negedge clk);
    cmd_valid = 1'b1; cmd = c; data_in = d;
    waited = 0;
    while (!cmd_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!cmd_ready) begin
      chk("accept_timeout", 0, 1);
      cmd_valid = 1'b0;
      return;
    end
    @(negedge clk);
    cmd_valid = 1'b0; cmd = 3'($urandom); data_in = 4'($urandom);
    chk("s1_ready", cmd_ready, 0);
    chk("s1_busy", busy, 1);
    chk("s1_ext_data", ext_data, d);
    cyc = 1; na = 0; nb = 0;
    forever begin
      na += int'(load_a);
      nb += int'(load_b);
      if (in_sel == 2'b11) chk("in_sel_11", in_sel, 0);
      if (done || cyc >= 8) break;
      @(negedge clk);
      cyc++;
    end
    chk("done_latency", cyc, ecyc);
    chk("load_a_steps", na, ena);
    chk("load_b_steps", nb, enb);
    @(negedge clk);
    chk("ready_after_done", cmd_ready, 1);
    chk("done_pulse", done, 0);
    chk("reg_a", ra, ea);
    chk("reg_b", rb, eb);
    ma = ea; mb = eb;
  endtask

  typedef struct {
    logic [2:0] c;
    logic [3:0] d;
    logic [3:0] ea;
    logic [3:0] eb;
  } vec_t;

  vec_t vecs[14];

  initial begin
    vecs[0]  = '{3'd1, 4'h5, 4'h5, 4'h0};
    vecs[1]  = '{3'd2, 4'h3, 4'h5, 4'h3};
    vecs[2]  = '{3'd3, 4'h0, 4'h8, 4'h3};
    vecs[3]  = '{3'd1, 4'h2, 4'h2, 4'h3};
    vecs[4]  = '{3'd2, 4'h5, 4'h2, 4'h5};
    vecs[5]  = '{3'd4, 4'h0, 4'hD, 4'h5};
    vecs[6]  = '{3'd5, 4'h0, 4'hD, 4'hD};
    vecs[7]  = '{3'd1, 4'h9, 4'h9, 4'hD};
    vecs[8]  = '{3'd2, 4'h6, 4'h9, 4'h6};
    vecs[9]  = '{3'd6, 4'h0, 4'h6, 4'h9};
    vecs[10] = '{3'd1, 4'h7, 4'h7, 4'h9};
    vecs[11] = '{3'd2, 4'h1, 4'h7, 4'h1};
    vecs[12] = '{3'd7, 4'h0, 4'h0, 4'h0};
    vecs[13] = '{3'd0, 4'hE, 4'h0, 4'h0};

    // Reset held for two cycles, then idle with nothing offered.
    repeat (2) @(negedge clk);
    chk_idle("rst");
    chk("rst_ext", ext_data, 0);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk_idle("idle");
    end

    foreach (vecs[i]) begin
      run_cmd(vecs[i].c, vecs[i].d);
      chk("vec_a", ra, vecs[i].ea);
      chk("vec_b", rb, vecs[i].eb);
    end

    // SWAP step pattern with an LDA held pending throughout.
    run_cmd(3'd1, 4'h9);
    run_cmd(3'd2, 4'h6);
    @(negedge clk);
    cmd_valid = 1'b1; cmd = 3'd6; data_in = 4'h0;
    @(negedge clk);
    cmd = 3'd1; data_in = 4'hC;
    chk("sw1_strobe", {load_a, load_b, in_sel, alu_op, done, busy}, 8'b10_01_10_0_1);
    @(negedge clk);
    chk("sw2_strobe", {load_a, load_b, in_sel, alu_op, done, busy}, 8'b01_01_10_0_1);
    @(negedge clk);
    chk("sw3_strobe", {load_a, load_b, in_sel, alu_op, done, busy}, 8'b10_01_10_1_1);
    @(negedge clk);
    chk("sw_end_ready", cmd_ready, 1);
    chk("sw_end_ab", {ra, rb}, 8'h69);
    chk("sw_ext_held", ext_data, 0);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("pend_lda_s1", {busy, load_a, load_b}, 3'b110);
    chk("pend_lda_ext", ext_data, 4'hC);
    @(negedge clk);
    chk("pend_lda_a", ra, 4'hC);
    chk("pend_lda_b", rb, 4'h9);
    ma = 4'hC; mb = 4'h9;

    // Asynchronous reset in the middle of S2 of a SWAP.
    run_cmd(3'd1, 4'h9);
    run_cmd(3'd2, 4'h6);
    @(negedge clk);
    cmd_valid = 1'b1; cmd = 3'd6; data_in = 4'hA;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("s2_load_b", load_b, 1);
    #2 rst = 1'b1;
    #1;
    chk_idle("async_rst");
    chk("async_rst_ext", ext_data, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("abort_a", ra, 4'hF);
    chk("abort_b", rb, 4'h6);
    ma = 4'hF; mb = 4'h6;

    // Randomized command stream against the command-level model.
    for (int k = 0; k < 150; k++) begin
      run_cmd(3'($urandom_range(0, 7)), 4'($urandom));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
